// File: rtl/ascon_ti_pkg.sv
// Shared constants, state encoding and LFSR step function for the
// Ascon threshold-implementation masking front end.
package ascon_ti_pkg;

  localparam int NUM_WORDS  = 5;
  localparam int NUM_SHARES = 3;
  localparam int WORD_W     = 64;

  // Feedback taps of the 64-bit Fibonacci LFSR
  localparam int TAP0 = 63;
  localparam int TAP1 = 62;
  localparam int TAP2 = 60;
  localparam int TAP3 = 59;

  localparam logic [WORD_W-1:0] DEFAULT_SEED = 64'hACE1_5EED_0BAD_C0DE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic logic [WORD_W-1:0] lfsr_next(input logic [WORD_W-1:0] v);
    return {v[WORD_W-2:0], v[TAP0] ^ v[TAP1] ^ v[TAP2] ^ v[TAP3]};
  endfunction

endpackage

// File: rtl/ascon_lfsr64.sv
// 64-bit mask LFSR; an all-zero load is replaced by SEED so the
// register can never lock up in the zero state.
module ascon_lfsr64
  import ascon_ti_pkg::*;
#(
  parameter logic [WORD_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] load_val,
  input  logic              step,
  output logic [WORD_W-1:0] q
);

  logic [WORD_W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= SEED;
    end else if (load) begin
      r_q <= (load_val == '0) ? SEED : load_val;
    end else if (step) begin
      r_q <= lfsr_next(r_q);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/ascon_ti_share_gen.sv
// Splits one unmasked 320-bit Ascon state into three Boolean shares per
// word, drawing one fresh 64-bit mask per cycle over ten GEN cycles.
module ascon_ti_share_gen
  import ascon_ti_pkg::*;
#(
  parameter logic [WORD_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_valid,
  input  logic [WORD_W-1:0] seed,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] x0,
  input  logic [WORD_W-1:0] x1,
  input  logic [WORD_W-1:0] x2,
  input  logic [WORD_W-1:0] x3,
  input  logic [WORD_W-1:0] x4,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] x0_0,
  output logic [WORD_W-1:0] x0_1,
  output logic [WORD_W-1:0] x0_2,
  output logic [WORD_W-1:0] x1_0,
  output logic [WORD_W-1:0] x1_1,
  output logic [WORD_W-1:0] x1_2,
  output logic [WORD_W-1:0] x2_0,
  output logic [WORD_W-1:0] x2_1,
  output logic [WORD_W-1:0] x2_2,
  output logic [WORD_W-1:0] x3_0,
  output logic [WORD_W-1:0] x3_1,
  output logic [WORD_W-1:0] x3_2,
  output logic [WORD_W-1:0] x4_0,
  output logic [WORD_W-1:0] x4_1,
  output logic [WORD_W-1:0] x4_2,
  output logic              busy
);

  state_t                             r_state;
  state_t                             w_next;
  logic [3:0]                         r_cnt;
  logic [NUM_WORDS-1:0][WORD_W-1:0]   r_s0, r_s1, r_s2;
  logic [NUM_WORDS-1:0][WORD_W-1:0]   w_x;
  logic [WORD_W-1:0]                  w_r;
  logic [2:0]                         w_word;
  logic                               w_accept;

  assign w_x      = {x4, x3, x2, x1, x0};
  assign w_word   = r_cnt[3:1];
  assign w_accept = (r_state == IDLE) && in_valid;

  // Mask source: the value seen here is the mask for this GEN cycle
  ascon_lfsr64 #(.SEED(SEED)) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     ((r_state == IDLE) && seed_valid),
    .load_val (seed),
    .step     (r_state == GEN),
    .q        (w_r)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)     w_next = GEN;
      GEN:     if (r_cnt == 4'd9) w_next = HOLD;
      HOLD:    if (out_ready)    w_next = IDLE;
      default:                   w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    busy      = (r_state == GEN) || (r_state == HOLD);
    out_valid = (r_state == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (r_state == GEN) begin
      r_cnt <= (r_cnt == 4'd9) ? 4'd0 : r_cnt + 4'd1;
    end
  end

  // Even cnt fills share 1, odd cnt share 2; share 0 absorbs both masks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0 <= '0;
      r_s1 <= '0;
      r_s2 <= '0;
    end else if (w_accept) begin
      r_s0 <= w_x;
      r_s1 <= '0;
      r_s2 <= '0;
    end else if (r_state == GEN) begin
      for (int w = 0; w < NUM_WORDS; w++) begin
        if (w_word == 3'(w)) begin
          if (!r_cnt[0]) r_s1[w] <= w_r;
          else           r_s2[w] <= w_r;
          r_s0[w] <= r_s0[w] ^ w_r;
        end
      end
    end
  end

  assign x0_0 = r_s0[0];
  assign x0_1 = r_s1[0];
  assign x0_2 = r_s2[0];
  assign x1_0 = r_s0[1];
  assign x1_1 = r_s1[1];
  assign x1_2 = r_s2[1];
  assign x2_0 = r_s0[2];
  assign x2_1 = r_s1[2];
  assign x2_2 = r_s2[2];
  assign x3_0 = r_s0[3];
  assign x3_1 = r_s1[3];
  assign x3_2 = r_s2[3];
  assign x4_0 = r_s0[4];
  assign x4_1 = r_s1[4];
  assign x4_2 = r_s2[4];

endmodule

// File: tb/tb_ascon_ti_share_gen.sv
// Directed bench for ascon_ti_share_gen with an independent LFSR model.
module tb_ascon_ti_share_gen;

  localparam logic [63:0] SEED_C = 64'hACE1_5EED_0BAD_C0DE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        seed_valid = 1'b0;
  logic [63:0] seed = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] x0 = '0, x1 = '0, x2 = '0, x3 = '0, x4 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] x0_0, x0_1, x0_2, x1_0, x1_1, x1_2, x2_0, x2_1, x2_2;
  logic [63:0] x3_0, x3_1, x3_2, x4_0, x4_1, x4_2;
  logic        busy;

  logic [4:0][63:0] s0, s1, s2;
  assign s0 = {x4_0, x3_0, x2_0, x1_0, x0_0};
  assign s1 = {x4_1, x3_1, x2_1, x1_1, x0_1};
  assign s2 = {x4_2, x3_2, x2_2, x1_2, x0_2};

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [63:0] m_lfsr = SEED_C;
  logic [4:0][63:0] xv, rnd, e1_out;
  logic [63:0] rec_x0_1;

  ascon_ti_share_gen dut (
    .clk(clk), .rst_n(rst_n), .seed_valid(seed_valid), .seed(seed),
    .in_valid(in_valid), .in_ready(in_ready),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4),
    .out_valid(out_valid), .out_ready(out_ready),
    .x0_0(x0_0), .x0_1(x0_1), .x0_2(x0_2),
    .x1_0(x1_0), .x1_1(x1_1), .x1_2(x1_2),
    .x2_0(x2_0), .x2_1(x2_1), .x2_2(x2_2),
    .x3_0(x3_0), .x3_1(x3_1), .x3_2(x3_2),
    .x4_0(x4_0), .x4_1(x4_1), .x4_2(x4_2),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mstep(input logic [63:0] v);
    return {v[62:0], v[63] ^ v[62] ^ v[60] ^ v[59]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_in_ready"},  64'(in_ready),  64'd1);
    check({tag, "_busy"},      64'(busy),      64'd0);
    for (int w = 0; w < 5; w++) begin
      check($sformatf("%s_s0_w%0d", tag, w), s0[w], 64'd0);
      check($sformatf("%s_s1_w%0d", tag, w), s1[w], 64'd0);
      check($sformatf("%s_s2_w%0d", tag, w), s2[w], 64'd0);
    end
  endtask

  task automatic load_seed(input logic [63:0] sd);
    seed_valid = 1'b1;
    seed       = sd;
    tick();
    seed_valid = 1'b0;
    m_lfsr     = (sd == 64'd0) ? SEED_C : sd;
  endtask

  // One full transaction: accept, 10 GEN cycles, optional backpressure, handshake
  task automatic run_state(input logic [4:0][63:0] xs, input bit do_seed,
                           input logic [63:0] sd, input int hold,
                           output logic [4:0][63:0] e1);
    logic [4:0][63:0] e0, e2;
    check("pre_in_ready", 64'(in_ready), 64'd1);
    {x4, x3, x2, x1, x0} = xs;
    in_valid   = 1'b1;
    seed_valid = do_seed;
    seed       = sd;
    if (do_seed) m_lfsr = (sd == 64'd0) ? SEED_C : sd;
    tick();
    in_valid   = 1'b0;
    seed_valid = 1'b0;
    for (int w = 0; w < 5; w++) begin
      e1[w]  = m_lfsr;
      m_lfsr = mstep(m_lfsr);
      e2[w]  = m_lfsr;
      m_lfsr = mstep(m_lfsr);
      e0[w]  = xs[w] ^ e1[w] ^ e2[w];
    end
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("out_valid_lat_c%0d", i), 64'(out_valid), (i == 10) ? 64'd1 : 64'd0);
      if (i == 1) check("busy_gen", 64'(busy), 64'd1);
    end
    for (int w = 0; w < 5; w++) begin
      check($sformatf("share0_w%0d", w), s0[w], e0[w]);
      check($sformatf("share1_w%0d", w), s1[w], e1[w]);
      check($sformatf("share2_w%0d", w), s2[w], e2[w]);
      check($sformatf("recombine_w%0d", w), s0[w] ^ s1[w] ^ s2[w], xs[w]);
    end
    check("hold_in_ready", 64'(in_ready), 64'd0);
    for (int c = 0; c < hold; c++) begin
      in_valid = c[0];
      x0       = ~xs[0];
      tick();
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready",  64'(in_ready),  64'd0);
      check("bp_busy",      64'(busy),      64'd1);
      for (int w = 0; w < 5; w++) begin
        check($sformatf("bp_s0_w%0d", w), s0[w], e0[w]);
        check($sformatf("bp_s1_w%0d", w), s1[w], e1[w]);
        check($sformatf("bp_s2_w%0d", w), s2[w], e2[w]);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_out_valid", 64'(out_valid), 64'd0);
    check("post_in_ready",  64'(in_ready),  64'd1);
    check("post_busy",      64'(busy),      64'd0);
  endtask

  initial begin
    for (int w = 0; w < 5; w++) xv[w] = 64'h0123456789ABCDEF ^ 64'(w);

    // Power-on reset
    rst_n = 1'b0;
    repeat (3) tick();
    check_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reference run straight after reset, recorded for the mid-run reset case
    run_state(xv, 1'b0, 64'd0, 0, e1_out);
    check("por_first_mask", x0_1, SEED_C);
    rec_x0_1 = x0_1;

    // Seed 1 with an all-zero state: masks are successive powers of two
    load_seed(64'd1);
    run_state('0, 1'b0, 64'd0, 0, e1_out);
    for (int w = 0; w < 5; w++) begin
      check($sformatf("pow2_s1_w%0d", w), s1[w], 64'd1 << (2 * w));
      check($sformatf("pow2_s2_w%0d", w), s2[w], 64'd1 << (2 * w + 1));
      check($sformatf("pow2_s0_w%0d", w), s0[w], 64'd3 << (2 * w));
    end

    // Random seed, fixed state, then a long run of random states
    load_seed({$urandom, $urandom});
    run_state(xv, 1'b0, 64'd0, 0, e1_out);
    for (int n = 0; n < 1000; n++) begin
      for (int w = 0; w < 5; w++) rnd[w] = {$urandom, $urandom};
      if (n % 100 == 50) run_state(rnd, 1'b1, {$urandom, $urandom}, 0, e1_out);
      else               run_state(rnd, 1'b0, 64'd0, 0, e1_out);
    end

    // Backpressure: seven cycles of out_ready low with in_valid pulses
    run_state(xv, 1'b0, 64'd0, 7, e1_out);

    // Zero seed falls back to the default seed
    load_seed(64'd0);
    run_state('0, 1'b0, 64'd0, 0, e1_out);
    check("zero_seed_mask", x0_1, SEED_C);

    // Seed load and state accept in the same cycle
    run_state('0, 1'b1, 64'h0F1E_2D3C_4B5A_6978, 0, e1_out);
    check("seed_with_accept", x0_1, 64'h0F1E_2D3C_4B5A_6978);

    // Asynchronous reset in the middle of GEN (cnt==4)
    {x4, x3, x2, x1, x0} = xv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("pre_reset_busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst_n  = 1'b1;
    m_lfsr = SEED_C;
    tick();
    check("after_rst_out_valid", 64'(out_valid), 64'd0);
    run_state(xv, 1'b0, 64'd0, 0, e1_out);
    check("rst_repeat_mask", x0_1, rec_x0_1);
    run_state(xv, 1'b0, 64'd0, 0, e1_out);
    check("b2b_masks_differ", 64'(x0_1 != rec_x0_1), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
